// File: rtl/measure_bcd_conv_if.sv
// ============================================================================
// Module      : measure_bcd_conv_if
// Description : Bundle of binary measurement inputs and packed-BCD results
//               exchanged between the measurement stage, the converter and
//               the display/overlay logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface measure_bcd_conv_if;
  logic [19:0] ad_freq;
  logic [7:0]  ad_vpp;
  logic [7:0]  ad_max;
  logic [7:0]  ad_min;
  logic [27:0] freq_bcd;
  logic [15:0] vpp_bcd;
  logic [11:0] max_bcd;
  logic [11:0] min_bcd;
  logic        bcd_valid;
  logic        busy;

  // Measurement side: supplies binary results, observes BCD results.
  modport master (
    output ad_freq, ad_vpp, ad_max, ad_min,
    input  freq_bcd, vpp_bcd, max_bcd, min_bcd, bcd_valid, busy
  );

  // Converter side.
  modport slave (
    input  ad_freq, ad_vpp, ad_max, ad_min,
    output freq_bcd, vpp_bcd, max_bcd, min_bcd, bcd_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/measure_bcd_conv.sv
// ============================================================================
// Module      : measure_bcd_conv
// Description : Periodically snapshots frequency, Vpp, max and min results,
//               scales Vpp to millivolts and converts all four to packed BCD
//               with a sequential double-dabble (one shift per clock).
//               Optional macro MEAS_LEADING_ZERO_BLANK_EN replaces leading
//               zero digits (above the LSD) with the blank code 4'hF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module measure_bcd_conv #(
  parameter logic [31:0] CLK_FS     = 32'd50_000_000,
  parameter logic [31:0] REFRESH_HZ = 32'd10,
  parameter logic [13:0] VFS_MV     = 14'd10000
) (
  input  wire logic         clk,
  input  wire logic         rstn,
  measure_bcd_conv_if.slave bus
);

  localparam logic [31:0] PERIOD      = CLK_FS / REFRESH_HZ;
  localparam logic [31:0] PERIOD_LAST = PERIOD - 32'd1;
  localparam logic [4:0]  F_LAST      = 5'd19;  // 20 shifts for frequency
  localparam logic [4:0]  V_LAST      = 5'd13;  // 14 shifts for Vpp in mV
  localparam logic [4:0]  B_LAST      = 5'd7;   // 8 shifts for max/min

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CONV_F  = 3'd2,
    S_CONV_V  = 3'd3,
    S_CONV_MX = 3'd4,
    S_CONV_MN = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [31:0] cnt_q;
  logic        tick;

  // Shared double-dabble shifter: value to convert is left-aligned in bin.
  logic [27:0] sh_bcd_q, sh_bcd_d;
  logic [19:0] sh_bin_q, sh_bin_d;

  // Snapshot of the inputs still waiting for their turn in the shifter.
  logic [13:0] vmv_q, vmv_d;
  logic [7:0]  mx_q, mx_d;
  logic [7:0]  mn_q, mn_d;

  // Finished conversions, held until all four can be published together.
  logic [27:0] res_f_q, res_f_d;
  logic [15:0] res_v_q, res_v_d;
  logic [11:0] res_mx_q, res_mx_d;

  // Published outputs.
  logic [27:0] out_f_q, out_f_d;
  logic [15:0] out_v_q, out_v_d;
  logic [11:0] out_mx_q, out_mx_d;
  logic [11:0] out_mn_q, out_mn_d;
  logic        valid_q, valid_d;

  logic [21:0] prod;
  logic [27:0] adj;
  logic [27:0] step_bcd;
  logic [19:0] step_bin;
  logic [27:0] bl_f, bl_v, bl_mx, bl_mn;
  logic        unused_bits;

  // Vpp scaling: 8-bit code times full-scale mV, keep the integer part of /256.
  assign prod = {14'd0, bus.ad_vpp} * {8'd0, VFS_MV};

  assign tick = (cnt_q == PERIOD_LAST);

  // Free-running refresh counter, wraps at PERIOD-1 regardless of FSM state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // Double-dabble adjust: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj = sh_bcd_q;
    for (int i = 0; i < 7; i++) begin
      if (sh_bcd_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = sh_bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // The top adjusted bit never carries for values that fit 7 digits.
  assign step_bcd = {adj[26:0], sh_bin_q[19]};
  assign step_bin = {sh_bin_q[18:0], 1'b0};

`ifdef MEAS_LEADING_ZERO_BLANK_EN
  // Replace leading zero digits above the LSD of an nd-digit field with 4'hF.
  function automatic logic [27:0] blank_lz(input logic [27:0] v, input int nd);
    logic [27:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int i = 6; i >= 1; i--) begin
      if (i < nd && lead) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign bl_f  = blank_lz(res_f_q, 7);
  assign bl_v  = blank_lz({12'd0, res_v_q}, 4);
  assign bl_mx = blank_lz({16'd0, res_mx_q}, 3);
  assign bl_mn = blank_lz({16'd0, step_bcd[11:0]}, 3);
`else
  assign bl_f  = res_f_q;
  assign bl_v  = {12'd0, res_v_q};
  assign bl_mx = {16'd0, res_mx_q};
  assign bl_mn = {16'd0, step_bcd[11:0]};
`endif

  assign unused_bits = ^{adj[27], prod[7:0], bl_v[27:16], bl_mx[27:12], bl_mn[27:12]};

  // FSM state and step counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // FSM next state: each CONV stage ends when the step counter hits its last shift.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_CONV_F;
        step_d  = '0;
      end
      S_CONV_F: begin
        if (step_q == F_LAST) begin
          state_d = S_CONV_V;
          step_d  = '0;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      S_CONV_V: begin
        if (step_q == V_LAST) begin
          state_d = S_CONV_MX;
          step_d  = '0;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      S_CONV_MX: begin
        if (step_q == B_LAST) begin
          state_d = S_CONV_MN;
          step_d  = '0;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      S_CONV_MN: begin
        if (step_q == B_LAST) begin
          state_d = S_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Datapath next state: load snapshot, shift, hand off between stages, publish.
  always_comb begin
    sh_bcd_d = sh_bcd_q;
    sh_bin_d = sh_bin_q;
    vmv_d    = vmv_q;
    mx_d     = mx_q;
    mn_d     = mn_q;
    res_f_d  = res_f_q;
    res_v_d  = res_v_q;
    res_mx_d = res_mx_q;
    out_f_d  = out_f_q;
    out_v_d  = out_v_q;
    out_mx_d = out_mx_q;
    out_mn_d = out_mn_q;
    valid_d  = 1'b0;
    case (state_q)
      S_LOAD: begin
        sh_bcd_d = '0;
        sh_bin_d = bus.ad_freq;
        vmv_d    = prod[21:8];
        mx_d     = bus.ad_max;
        mn_d     = bus.ad_min;
      end
      S_CONV_F: begin
        sh_bcd_d = step_bcd;
        sh_bin_d = step_bin;
        if (step_q == F_LAST) begin
          res_f_d  = step_bcd;
          sh_bcd_d = '0;
          sh_bin_d = {vmv_q, 6'd0};
        end
      end
      S_CONV_V: begin
        sh_bcd_d = step_bcd;
        sh_bin_d = step_bin;
        if (step_q == V_LAST) begin
          res_v_d  = step_bcd[15:0];
          sh_bcd_d = '0;
          sh_bin_d = {mx_q, 12'd0};
        end
      end
      S_CONV_MX: begin
        sh_bcd_d = step_bcd;
        sh_bin_d = step_bin;
        if (step_q == B_LAST) begin
          res_mx_d = step_bcd[11:0];
          sh_bcd_d = '0;
          sh_bin_d = {mn_q, 12'd0};
        end
      end
      S_CONV_MN: begin
        sh_bcd_d = step_bcd;
        sh_bin_d = step_bin;
        // Publish on entry to DONE so outputs and the pulse appear in DONE together.
        if (step_q == B_LAST) begin
          out_f_d  = bl_f;
          out_v_d  = bl_v[15:0];
          out_mx_d = bl_mx[11:0];
          out_mn_d = bl_mn[11:0];
          valid_d  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset discards any partial conversion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_bcd_q <= '0;
      sh_bin_q <= '0;
      vmv_q    <= '0;
      mx_q     <= '0;
      mn_q     <= '0;
      res_f_q  <= '0;
      res_v_q  <= '0;
      res_mx_q <= '0;
      out_f_q  <= '0;
      out_v_q  <= '0;
      out_mx_q <= '0;
      out_mn_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      sh_bcd_q <= sh_bcd_d;
      sh_bin_q <= sh_bin_d;
      vmv_q    <= vmv_d;
      mx_q     <= mx_d;
      mn_q     <= mn_d;
      res_f_q  <= res_f_d;
      res_v_q  <= res_v_d;
      res_mx_q <= res_mx_d;
      out_f_q  <= out_f_d;
      out_v_q  <= out_v_d;
      out_mx_q <= out_mx_d;
      out_mn_q <= out_mn_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.freq_bcd  = out_f_q;
  assign bus.vpp_bcd   = out_v_q;
  assign bus.max_bcd   = out_mx_q;
  assign bus.min_bcd   = out_mn_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_measure_bcd_conv.sv
// ============================================================================
// Module      : tb_measure_bcd_conv
// Description : Self-checking bench for measure_bcd_conv (two instances:
//               PERIOD=100 for conversion checks, PERIOD=40 for tick drop).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_measure_bcd_conv;

  localparam int VFS = 10000;

  logic clk = 1'b0;
  logic rstn;
  logic rstn2;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vcnt1 = 0;
  int   v2_cyc[$];

  measure_bcd_conv_if ifc ();
  measure_bcd_conv_if ifc2 ();

  measure_bcd_conv #(.CLK_FS(32'd1000), .REFRESH_HZ(32'd10), .VFS_MV(14'd10000)) dut (
    .clk(clk), .rstn(rstn), .bus(ifc)
  );

  measure_bcd_conv #(.CLK_FS(32'd1000), .REFRESH_HZ(32'd25), .VFS_MV(14'd10000)) dut2 (
    .clk(clk), .rstn(rstn2), .bus(ifc2)
  );

  always #5 clk = ~clk;

  // Cycle stamp and bcd_valid pulse monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.bcd_valid === 1'b1) vcnt1++;
    if (ifc2.bcd_valid === 1'b1) v2_cyc.push_back(cyc);
  end

  // Decimal digits of val as packed BCD, optionally with leading-zero blanking.
  function automatic logic [31:0] mdl(input int unsigned val, input int nd);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = val;
    for (int i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef MEAS_LEADING_ZERO_BLANK_EN
    for (int i = nd - 1; i >= 1; i--) begin
      if (r[i*4 +: 4] != 4'd0) break;
      r[i*4 +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic int unsigned vpp_mv(input logic [7:0] v);
    return (int'(v) * VFS) / 256;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd();
    return $urandom;
  endfunction

  // One snapshot/conversion: present inputs, wait for LOAD, disturb inputs
  // during conversion, then check latency, values, pulse width and hold.
  task automatic run_conv(input logic [19:0] f, input logic [7:0] v,
                          input logic [7:0] mx, input logic [7:0] mn);
    int t;
    logic [31:0] r;
    ifc.ad_freq = f;
    ifc.ad_vpp  = v;
    ifc.ad_max  = mx;
    ifc.ad_min  = mn;
    t = 0;
    while (ifc.busy !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("load_seen", {31'd0, ifc.busy}, 32'd1);
    @(negedge clk);
    r = rnd();
    ifc.ad_freq = f + 20'd1000;
    ifc.ad_vpp  = r[7:0];
    ifc.ad_max  = r[15:8];
    ifc.ad_min  = r[23:16];
    t = 1;
    while (ifc.bcd_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("latency", 32'(t), 32'd51);
    check("freq_bcd", {4'd0, ifc.freq_bcd}, mdl(int'(f), 7));
    check("vpp_bcd", {16'd0, ifc.vpp_bcd}, mdl(vpp_mv(v), 4));
    check("max_bcd", {20'd0, ifc.max_bcd}, mdl(int'(mx), 3));
    check("min_bcd", {20'd0, ifc.min_bcd}, mdl(int'(mn), 3));
    check("busy_in_done", {31'd0, ifc.busy}, 32'd1);
    @(negedge clk);
    check("valid_one_cycle", {31'd0, ifc.bcd_valid}, 32'd0);
    check("freq_hold", {4'd0, ifc.freq_bcd}, mdl(int'(f), 7));
    check("busy_after_done", {31'd0, ifc.busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int t;
    int vsave;

    // Reset held while inputs wiggle: nothing may leave the block.
    rstn  = 1'b0;
    rstn2 = 1'b0;
    r = rnd();
    ifc.ad_freq = r[19:0];
    ifc.ad_vpp  = r[27:20];
    ifc.ad_max  = 8'd99;
    ifc.ad_min  = 8'd7;
    ifc2.ad_freq = 20'd123456;
    ifc2.ad_vpp  = 8'd77;
    ifc2.ad_max  = 8'd250;
    ifc2.ad_min  = 8'd3;
    repeat (150) @(negedge clk);
    check("rst_freq", {4'd0, ifc.freq_bcd}, 32'd0);
    check("rst_vpp", {16'd0, ifc.vpp_bcd}, 32'd0);
    check("rst_max", {20'd0, ifc.max_bcd}, 32'd0);
    check("rst_min", {20'd0, ifc.min_bcd}, 32'd0);
    check("rst_busy", {31'd0, ifc.busy}, 32'd0);
    check("rst_no_valid", 32'(vcnt1), 32'd0);
    rstn  = 1'b1;
    rstn2 = 1'b1;

    // Basic vector, also against literal BCD images.
    run_conv(20'd1048575, 8'd128, 8'd200, 8'd72);
    check("basic_freq_lit", {4'd0, ifc.freq_bcd}, 32'h1048575);
    check("basic_vpp_lit", {16'd0, ifc.vpp_bcd}, 32'h5000);
    check("basic_max_lit", {20'd0, ifc.max_bcd}, 32'h200);

    // Scaling bounds.
    r = rnd();
    run_conv(r[19:0], 8'd255, r[27:20], 8'd1);
    check("vpp_full_lit", {16'd0, ifc.vpp_bcd}, 32'h9960);
    r = rnd();
    run_conv(r[19:0], 8'd0, 8'd0, r[31:24]);

    // Leading zeros and a zero LSD-only value.
    run_conv(20'd50, 8'd10, 8'd9, 8'd0);

    // Snapshot: input moves 1000 -> 2000 mid-conversion.
    run_conv(20'd1000, 8'd64, 8'd100, 8'd10);

    // Random patterns.
    for (int k = 0; k < 6; k++) begin
      r = rnd();
      t = int'($urandom_range(0, 1048575));
      run_conv(20'(t), r[7:0], r[15:8], r[23:16]);
    end

    // Reset 30 cycles after the tick: abort, no publish, outputs cleared.
    t = 0;
    while (ifc.busy !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("abort_load_seen", {31'd0, ifc.busy}, 32'd1);
    repeat (29) @(negedge clk);
    vsave = vcnt1;
    rstn = 1'b0;
    #1;
    check("abort_freq", {4'd0, ifc.freq_bcd}, 32'd0);
    check("abort_vpp", {16'd0, ifc.vpp_bcd}, 32'd0);
    check("abort_busy", {31'd0, ifc.busy}, 32'd0);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_valid", 32'(vcnt1), 32'(vsave));
    check("abort_min_zero", {20'd0, ifc.min_bcd}, 32'd0);
    check("abort_max_zero", {20'd0, ifc.max_bcd}, 32'd0);

    // Fast-refresh instance: every second tick lands while busy.
    check("drop_count", {31'd0, (v2_cyc.size() >= 6)}, 32'd1);
    for (int k = 1; k < 6 && k < v2_cyc.size(); k++) begin
      check("drop_interval", 32'(v2_cyc[k] - v2_cyc[k-1]), 32'd80);
    end
    check("drop_freq", {4'd0, ifc2.freq_bcd}, mdl(123456, 7));
    check("drop_vpp", {16'd0, ifc2.vpp_bcd}, mdl(vpp_mv(8'd77), 4));
    check("drop_min", {20'd0, ifc2.min_bcd}, mdl(3, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
